conv_layer_ctrl: RTL and testbench
==================================

# conv_layer_ctrl

Control unit for one 1-D convolution layer in the streaming CNN accelerator. It sits beside the layer's input memory, weight ROM, and MAC/accumulator datapath. It accepts N input samples over a valid/ready stream into the input memory, then sequences the datapath to compute N−M+1 outputs. It presents each finished accumulator value on a valid/ready output stream. The datapath itself (memories, multiplier, accumulator, output register) is outside this block; this block drives only addresses, strobes and handshake signals.

## Interface
- N, 64, input vector length (≥ M)
- M, 9, filter taps (≥ 2)
- AX, $clog2(N), input memory address width
- AW, $clog2(M), weight address width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- x_valid  in  1  upstream sample valid
- x_ready  out  1  block accepts a sample this cycle
- wr_en_x  out  1  input memory write enable (= x_valid && x_ready)
- addr_x  out  AX  input memory address (write in LOAD, read in COMPUTE)
- addr_w  out  AW  weight ROM read address
- clear_acc  out  1  accumulator loads product instead of adding
- en_acc  out  1  accumulator update enable
- y_valid  out  1  accumulator holds a finished output
- y_ready  in  1  downstream accepts output
- layer_done  out  1  one-cycle pulse after the last output handshake

## Operation
- States: LOAD, COMPUTE, OUTPUT. Reset state is LOAD. Counters ld (0..N−1), k (output index, 0..N−M), t (tap, 0..M−1) all reset to 0.
- LOAD
  - x_ready=1; addr_x=ld.
  - On each x_valid && x_ready, wr_en_x=1 and ld increments.
  - When ld=N−1 is accepted, ld←0 and go to COMPUTE with k=0, t=0.
  - Cycles with x_valid=0 change nothing.
- COMPUTE
  - x_ready=0. Each cycle issues one read: addr_x=k+t, addr_w=t; t increments.
  - Memories have 1-cycle read latency. A registered issue flag (rd_v) drives en_acc one cycle after each issue.
  - clear_acc=1 with the en_acc for t=0 only.
  - After issuing t=M−1: t←0, go to OUTPUT.
- OUTPUT
  - The first cycle in OUTPUT carries the final en_acc (last tap). y_valid is 0 in that cycle.
  - y_valid=1 from the following cycle and is held with addresses frozen until y_ready=1.
  - On handshake: if k<N−M, k increments and go to COMPUTE. Otherwise k←0, pulse layer_done, go to LOAD.
- addr_x/addr_w are don't-care-stable in OUTPUT; they hold their last values.
- k+t never exceeds N−1. No wrap-around of addr_x is permitted. A mismatch is a design error, asserted in the bench.
- x_ready and y_valid are never both 1.
- Reset values: x_ready=1 (combinational from LOAD), wr_en_x=0, addr_x=0, addr_w=0, clear_acc=0, en_acc=0, y_valid=0, layer_done=0.
- Reset asserted mid-operation: immediate return to LOAD. Counters and the rd_v pipeline are zeroed, so no stray en_acc follows. Partially loaded data is discarded logically: the next load restarts at address 0.

## Timing
- Load: N accepted handshakes, 1 sample/cycle maximum.
- Per output with y_ready held high: M issue cycles + 1 final-accumulate cycle + 1 handshake cycle = M+2 cycles.
- Output latency: y_valid rises 2 cycles after the issue of tap M−1.
- y_valid, en_acc, clear_acc and layer_done are registered outputs. x_ready and wr_en_x are combinational from state and x_valid.
- Simultaneous y handshake and state change: next COMPUTE issue occurs the cycle after the handshake. There is no overlap between outputs.
- layer_done is asserted in the cycle after the last handshake, coincident with x_ready returning to 1.

## Test plan
- Reset: hold reset, then release → x_ready=1, y_valid=0, en_acc=0, addr_x=0.
  - Assert reset asynchronously between edges → outputs clear without a clock edge.
- Load, N=64, x_valid constant 1 → wr_en_x on 64 consecutive cycles with addr_x=0..63, then x_ready=0 and addr_x=0, addr_w=0 in the first COMPUTE cycle.
- Load with random x_valid gaps (≈50%) → exactly 64 writes, addresses strictly increasing with no skips or repeats.
- Output 0, M=9, y_ready=1 → addr_x 0..8 and addr_w 0..8 over 9 cycles; en_acc 9 cycles starting one cycle later, clear_acc only on the first; y_valid high for exactly 1 cycle, 2 cycles after addr_w=8.
- Backpressure: y_ready=0 for 5 cycles on output 3 → y_valid held 5+1 cycles, no en_acc, addresses frozen. Next issue after the handshake has addr_x=4.
- Full layer with random y_ready → 56 output handshakes, one layer_done pulse, return to LOAD.
  - Reset mid-COMPUTE (output 10, tap 4) → no en_acc after reset; the next load starts at addr_x=0.

Source files
------------

// File: rtl/conv_layer_ctrl_if.sv
// Signal bundle between the convolution layer controller and its
// environment: input sample stream, memory/ROM addressing, accumulator
// strobes and output stream handshake.
interface conv_layer_ctrl_if #(
    parameter int N  = 64,
    parameter int M  = 9,
    parameter int AX = $clog2(N),
    parameter int AW = $clog2(M)
) ();

    logic          x_valid;
    logic          x_ready;
    logic          wr_en_x;
    logic [AX-1:0] addr_x;
    logic [AW-1:0] addr_w;
    logic          clear_acc;
    logic          en_acc;
    logic          y_valid;
    logic          y_ready;
    logic          layer_done;

    // Controller side: drives addresses, strobes and handshake outputs.
    modport master (
        input  x_valid,
        input  y_ready,
        output x_ready,
        output wr_en_x,
        output addr_x,
        output addr_w,
        output clear_acc,
        output en_acc,
        output y_valid,
        output layer_done
    );

    // Environment side: upstream source, downstream sink and datapath.
    modport slave (
        output x_valid,
        output y_ready,
        input  x_ready,
        input  wr_en_x,
        input  addr_x,
        input  addr_w,
        input  clear_acc,
        input  en_acc,
        input  y_valid,
        input  layer_done
    );

endinterface

// File: rtl/conv_layer_ctrl.sv
// Sequencer for one 1-D convolution layer: loads N samples into the input
// memory, then walks the MAC datapath through N-M+1 dot products of M taps
// each, presenting every finished accumulator value on a valid/ready stream.
module conv_layer_ctrl #(
    parameter int N  = 64,
    parameter int M  = 9,
    parameter int AX = $clog2(N),
    parameter int AW = $clog2(M)
) (
    input  logic              clk,
    input  logic              reset,
    conv_layer_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    localparam logic [AX-1:0] LD_LAST = AX'(N - 1);
    localparam logic [AX-1:0] K_LAST  = AX'(N - M);
    localparam logic [AW-1:0] T_LAST  = AW'(M - 1);

    state_t        state_q, state_d;
    logic [AX-1:0] ld_q, ld_d;
    logic [AX-1:0] k_q, k_d;
    logic [AW-1:0] t_q, t_d;
    // Last issued read addresses, so the memories see stable addresses
    // while a result waits for the downstream handshake.
    logic [AX-1:0] ax_hold_q, ax_hold_d;
    logic [AW-1:0] aw_hold_q, aw_hold_d;
    // Read-issue flag delayed by the memory latency; it is the accumulate enable.
    logic          rd_v_q, rd_v_d;
    logic          rd_clr_q, rd_clr_d;
    logic          y_valid_q, y_valid_d;
    logic          done_q, done_d;

    logic          accept;
    logic [AX-1:0] issue_addr;

    assign accept     = (state_q == S_LOAD) && bus.x_valid;
    assign issue_addr = k_q + AX'(t_q);

    assign bus.x_ready    = (state_q == S_LOAD);
    assign bus.wr_en_x    = accept;
    assign bus.en_acc     = rd_v_q;
    assign bus.clear_acc  = rd_clr_q;
    assign bus.y_valid    = y_valid_q;
    assign bus.layer_done = done_q;

    // Address mux: write pointer in LOAD, k+t read in COMPUTE, frozen otherwise.
    always_comb begin
        bus.addr_x = ax_hold_q;
        bus.addr_w = aw_hold_q;
        case (state_q)
            S_LOAD: begin
                bus.addr_x = ld_q;
            end
            S_COMPUTE: begin
                bus.addr_x = issue_addr;
                bus.addr_w = t_q;
            end
            default: begin
                bus.addr_x = ax_hold_q;
                bus.addr_w = aw_hold_q;
            end
        endcase
    end

    // Next-state, counter and registered-strobe logic.
    always_comb begin
        state_d   = state_q;
        ld_d      = ld_q;
        k_d       = k_q;
        t_d       = t_q;
        ax_hold_d = ax_hold_q;
        aw_hold_d = aw_hold_q;
        rd_v_d    = 1'b0;
        rd_clr_d  = 1'b0;
        y_valid_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (ld_q == LD_LAST) begin
                        ld_d    = '0;
                        k_d     = '0;
                        t_d     = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        ld_d = ld_q + AX'(1);
                    end
                end
            end
            S_COMPUTE: begin
                rd_v_d    = 1'b1;
                rd_clr_d  = (t_q == '0);
                ax_hold_d = issue_addr;
                aw_hold_d = t_q;
                if (t_q == T_LAST) begin
                    t_d     = '0;
                    state_d = S_OUTPUT;
                end else begin
                    t_d = t_q + AW'(1);
                end
            end
            S_OUTPUT: begin
                // First OUTPUT cycle carries the last accumulate; valid rises
                // after it and holds until the handshake.
                y_valid_d = 1'b1;
                if (y_valid_q && bus.y_ready) begin
                    y_valid_d = 1'b0;
                    if (k_q < K_LAST) begin
                        k_d     = k_q + AX'(1);
                        state_d = S_COMPUTE;
                    end else begin
                        k_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and counter registers; reset returns to LOAD and kills any
    // in-flight accumulate enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_LOAD;
            ld_q      <= '0;
            k_q       <= '0;
            t_q       <= '0;
            ax_hold_q <= '0;
            aw_hold_q <= '0;
            rd_v_q    <= 1'b0;
            rd_clr_q  <= 1'b0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_q      <= ld_d;
            k_q       <= k_d;
            t_q       <= t_d;
            ax_hold_q <= ax_hold_d;
            aw_hold_q <= aw_hold_d;
            rd_v_q    <= rd_v_d;
            rd_clr_q  <= rd_clr_d;
            y_valid_q <= y_valid_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: a behavioural memory/ROM/accumulator datapath is
// driven by the controller's strobes; a reference convolution computed from
// the accepted samples fills a scoreboard that a monitor checks at each
// output handshake.
module tb_conv_layer_ctrl;

    localparam int N  = 64;
    localparam int M  = 9;
    localparam int AX = $clog2(N);
    localparam int AW = $clog2(M);
    localparam int NOUT = N - M + 1;

    logic clk;
    logic reset;

    conv_layer_ctrl_if #(.N(N), .M(M)) bus ();

    conv_layer_ctrl #(.N(N), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int xmem [2**AX];
    int wrom [2**AW];
    int xs   [N];
    int xdata;
    int rdx, rdw, acc;
    int exp_q [$];

    int hs_cnt   = 0;
    int done_cnt = 0;
    int en_cnt   = 0;
    int clr_cnt  = 0;
    int kk       = 0;
    int prev_ax  = 0;
    int prev_aw  = 0;

    task automatic chk_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // External datapath model: 1-cycle read latency memories and accumulator.
    always @(posedge clk) begin
        if (bus.wr_en_x) xmem[bus.addr_x] <= xdata;
        rdx <= xmem[bus.addr_x];
        rdw <= wrom[bus.addr_w];
        if (bus.en_acc) acc <= bus.clear_acc ? rdx * rdw : acc + rdx * rdw;
    end

    // Monitor: scoreboard pop on each output handshake plus per-cycle rules.
    always @(negedge clk) begin
        if (reset) begin
            en_cnt  = 0;
            clr_cnt = 0;
            kk      = 0;
        end else begin
            chk_eq("xready_yvalid_exclusive", int'(bus.x_ready && bus.y_valid), 0);
            if (bus.en_acc) begin
                chk_eq("addr_k_plus_t", prev_ax, kk + prev_aw);
                en_cnt++;
                if (bus.clear_acc) clr_cnt++;
            end
            if (bus.y_valid && bus.y_ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("scoreboard_nonempty", 0, 1);
                end else begin
                    chk_eq("y_value", acc, exp_q.pop_front());
                end
                chk_eq("en_acc_per_output", en_cnt, M);
                chk_eq("clear_acc_per_output", clr_cnt, 1);
                en_cnt  = 0;
                clr_cnt = 0;
                kk      = (kk == NOUT - 1) ? 0 : kk + 1;
                hs_cnt++;
            end
            if (bus.layer_done) done_cnt++;
        end
        prev_ax = int'(bus.addr_x);
        prev_aw = int'(bus.addr_w);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected();
        for (int k = 0; k < NOUT; k++) begin
            int s;
            s = 0;
            for (int t = 0; t < M; t++) s += xs[k + t] * wrom[t];
            exp_q.push_back(s);
        end
    endtask

    task automatic load_layer(input bit gaps);
        int widx;
        int n;
        bit v;
        widx = 0;
        n = 0;
        while (widx < N && n < 2000) begin
            cyc();
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.x_valid = v;
            xdata = int'($urandom_range(0, 255));
            smp();
            chk_eq("load_wr_en", int'(bus.wr_en_x), int'(v));
            if (v) begin
                chk_eq("load_addr", int'(bus.addr_x), widx);
                xs[widx] = xdata;
                widx++;
            end
            n++;
        end
        chk_eq("load_complete", widx, N);
        cyc();
        bus.x_valid = 1'b0;
        push_expected();
    endtask

    task automatic run_until_done(input int base_hs, input int base_done);
        int n;
        n = 0;
        while (done_cnt == base_done && n < 4000) begin
            cyc();
            bus.y_ready = 1'($urandom_range(0, 1));
            smp();
            n++;
        end
        chk_eq("layer_done_seen", done_cnt - base_done, 1);
        chk_eq("done_x_ready", int'(bus.x_ready), 1);
        chk_eq("outputs_per_layer", hs_cnt - base_hs, NOUT);
        chk_eq("scoreboard_drained", exp_q.size(), 0);
        smp();
        chk_eq("layer_done_pulse_len", int'(bus.layer_done), 0);
        chk_eq("layer_done_count", done_cnt - base_done, 1);
    endtask

    initial begin
        int base_hs, base_done, n, ax0, aw0;
        for (int t = 0; t < 2**AW; t++) wrom[t] = int'($urandom_range(0, 255));
        reset = 1'b1;
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b1;
        xdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        smp();
        chk_eq("rst_x_ready", int'(bus.x_ready), 1);
        chk_eq("rst_y_valid", int'(bus.y_valid), 0);
        chk_eq("rst_en_acc", int'(bus.en_acc), 0);
        chk_eq("rst_clear_acc", int'(bus.clear_acc), 0);
        chk_eq("rst_addr_x", int'(bus.addr_x), 0);
        chk_eq("rst_addr_w", int'(bus.addr_w), 0);
        chk_eq("rst_layer_done", int'(bus.layer_done), 0);

        // Layer 1: back-to-back load, directed timing of output 0 and 3.
        base_hs = hs_cnt;
        base_done = done_cnt;
        load_layer(1'b0);
        smp();
        chk_eq("c0_x_ready", int'(bus.x_ready), 0);
        for (int c = 0; c < M; c++) begin
            if (c > 0) smp();
            chk_eq("out0_addr_x", int'(bus.addr_x), c);
            chk_eq("out0_addr_w", int'(bus.addr_w), c);
        end
        smp();
        chk_eq("out0_final_en", int'(bus.en_acc), 1);
        chk_eq("out0_y_early", int'(bus.y_valid), 0);
        smp();
        chk_eq("out0_y_rise", int'(bus.y_valid), 1);
        smp();
        chk_eq("out0_y_one_cycle", int'(bus.y_valid), 0);

        n = 0;
        while (hs_cnt - base_hs < 3 && n < 200) begin smp(); n++; end
        chk_eq("reach_out3", hs_cnt - base_hs, 3);
        cyc();
        bus.y_ready = 1'b0;
        n = 0;
        smp();
        while (!bus.y_valid && n < 50) begin smp(); n++; end
        ax0 = int'(bus.addr_x);
        aw0 = int'(bus.addr_w);
        chk_eq("bp_frozen_addr_x", ax0, 3 + M - 1);
        chk_eq("bp_frozen_addr_w", aw0, M - 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) smp();
            chk_eq("bp_y_held", int'(bus.y_valid), 1);
            chk_eq("bp_no_en", int'(bus.en_acc), 0);
            chk_eq("bp_addr_x", int'(bus.addr_x), ax0);
            chk_eq("bp_addr_w", int'(bus.addr_w), aw0);
        end
        cyc();
        bus.y_ready = 1'b1;
        smp();
        chk_eq("bp_y_at_hs", int'(bus.y_valid), 1);
        smp();
        chk_eq("bp_next_addr_x", int'(bus.addr_x), 4);
        chk_eq("bp_next_addr_w", int'(bus.addr_w), 0);
        chk_eq("bp_next_y", int'(bus.y_valid), 0);
        run_until_done(base_hs, base_done);

        // Layer 2: gappy load, then reset in output 10 tap 4.
        base_hs = hs_cnt;
        load_layer(1'b1);
        n = 0;
        while (hs_cnt - base_hs < 10 && n < 2000) begin
            cyc();
            bus.y_ready = 1'($urandom_range(0, 1));
            smp();
            n++;
        end
        chk_eq("reach_out10", hs_cnt - base_hs, 10);
        repeat (5) @(posedge clk);
        #1;
        chk_eq("tap4_addr_w", int'(bus.addr_w), 4);
        chk_eq("tap4_addr_x", int'(bus.addr_x), 14);
        chk_eq("tap4_en_before_rst", int'(bus.en_acc), 1);
        #2 reset = 1'b1;
        #1;
        chk_eq("async_x_ready", int'(bus.x_ready), 1);
        chk_eq("async_en_acc", int'(bus.en_acc), 0);
        chk_eq("async_y_valid", int'(bus.y_valid), 0);
        chk_eq("async_addr_x", int'(bus.addr_x), 0);
        chk_eq("async_addr_w", int'(bus.addr_w), 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk_eq("post_rst_no_en", int'(bus.en_acc), 0);
        end

        // Layer 3: full reload from address 0 and a complete layer.
        base_hs = hs_cnt;
        base_done = done_cnt;
        load_layer(1'b0);
        run_until_done(base_hs, base_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
